// File: rtl/tile_lane_engine.sv
// Piano-tile playfield: scrolls one-hot tile rows per frame, judges key presses
// against the bottom row, keeps score/speed/fail state and renders RGB per pixel.
module tile_lane_engine #(
  parameter int                     NUM_LANES    = 5,
  parameter int                     NUM_ROWS     = 4,
  parameter int                     LANE_W       = 128,
  parameter int                     ROW_H        = 120,
  parameter logic [8*NUM_LANES-1:0] KEYCODES     = 40'h0E0D2C0907,
  parameter int                     INIT_SPEED   = 1,
  parameter int                     MAX_SPEED    = 7,
  parameter int                     SPEEDUP_HITS = 8,
  parameter logic [7:0]             LFSR_SEED    = 8'hA5
) (
  input  logic        pixel_clk,
  input  logic        Reset_n,
  input  logic        vs,
  input  logic        blank,
  input  logic [7:0]  keycode,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [15:0] score,
  output logic [2:0]  speed,
  output logic        game_over
);

  localparam int LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int RIW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int OW     = $clog2(ROW_H + MAX_SPEED);
  localparam int SW     = OW + 1;
  localparam int HCW    = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
  localparam int TARGET = NUM_ROWS - 1;

  localparam logic [11:0] RGB_OFF   = 12'h000;
  localparam logic [11:0] RGB_GRID  = 12'h888;
  localparam logic [11:0] RGB_FAIL  = 12'hF00;
  localparam logic [11:0] RGB_HIT   = 12'h0F0;
  localparam logic [11:0] RGB_TILE  = 12'h000;
  localparam logic [11:0] RGB_EMPTY = 12'hFFF;

  typedef logic [LW-1:0] lane_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL} state_t;

  function automatic lane_t preload_lane(input int r);
    return lane_t'(r % NUM_LANES);
  endfunction

  // Game state
  state_t            state_q, state_d;
  logic [OW-1:0]     offset_q, offset_d;
  logic [2:0]        speed_q, speed_d;
  logic [15:0]       score_q, score_d;
  logic              hit_q, hit_d;
  logic [HCW-1:0]    hit_cnt_q, hit_cnt_d;
  lane_t             fail_lane_q, fail_lane_d;
  lane_t             incoming_q, incoming_d;
  lane_t             rows_q [NUM_ROWS];
  lane_t             rows_d [NUM_ROWS];

  // Input edge detection and tile randomiser
  logic              vs_q;
  logic [7:0]        key_q;
  logic [7:0]        lfsr_q;
  logic              frame_tick, press;
  logic              key_valid;
  lane_t             key_lane;
  lane_t             lfsr_lane;

  assign frame_tick = vs & ~vs_q;
  assign press      = (keycode != 8'd0) && (key_q == 8'd0);
  assign lfsr_lane  = lane_t'(lfsr_q % 8'(NUM_LANES));

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q   <= 1'b0;
      key_q  <= 8'd0;
      lfsr_q <= LFSR_SEED;
    end else begin
      vs_q  <= vs;
      key_q <= keycode;
      if (frame_tick)
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_comb begin
    key_valid = 1'b0;
    key_lane  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (keycode == KEYCODES[8*i +: 8]) begin
        key_valid = 1'b1;
        key_lane  = lane_t'(i);
      end
    end
  end

  // NOTE: the tile rows are a handful of flops, not a RAM, so they get an
  // async reset like every other state bit; the playfield must be valid at once.
  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      offset_q    <= '0;
      speed_q     <= 3'(INIT_SPEED);
      score_q     <= '0;
      hit_q       <= 1'b0;
      hit_cnt_q   <= '0;
      fail_lane_q <= '0;
      incoming_q  <= '0;
      for (int r = 0; r < NUM_ROWS; r++) rows_q[r] <= preload_lane(r);
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      speed_q     <= speed_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      hit_cnt_q   <= hit_cnt_d;
      fail_lane_q <= fail_lane_d;
      incoming_q  <= incoming_d;
      rows_q      <= rows_d;
    end
  end

  logic [SW-1:0] scroll_sum;
  logic          judge_hit, judge_fail;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    speed_d     = speed_q;
    score_d     = score_q;
    hit_d       = hit_q;
    hit_cnt_d   = hit_cnt_q;
    fail_lane_d = fail_lane_q;
    incoming_d  = incoming_q;
    rows_d      = rows_q;
    judge_hit   = 1'b0;
    judge_fail  = 1'b0;
    scroll_sum  = SW'(offset_q) + SW'(speed_q);

    unique case (state_q)
      S_IDLE: begin
        if (press) state_d = S_RUN;
      end

      S_RUN: begin
        // The press is judged against the target row as it stands before any shift.
        if (press && key_valid) begin
          if (key_lane == rows_q[TARGET] && !hit_q) begin
            judge_hit = 1'b1;
            hit_d     = 1'b1;
            if (score_q != '1) score_d = score_q + 16'd1;
            if (hit_cnt_q == HCW'(SPEEDUP_HITS - 1)) begin
              hit_cnt_d = '0;
              if (speed_q < 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + HCW'(1);
            end
          end else begin
            judge_fail  = 1'b1;
            state_d     = S_FAIL;
            fail_lane_d = key_lane;
          end
        end

        if (!judge_fail && frame_tick) begin
          if (scroll_sum >= SW'(ROW_H)) begin
            if (!(hit_q || judge_hit)) begin
              state_d     = S_FAIL;
              fail_lane_d = rows_q[TARGET];
            end else begin
              for (int r = NUM_ROWS - 1; r > 0; r--) rows_d[r] = rows_q[r-1];
              rows_d[0]  = incoming_q;
              incoming_d = lfsr_lane;
              offset_d   = OW'(scroll_sum - SW'(ROW_H));
              hit_d      = 1'b0;
            end
          end else begin
            offset_d = OW'(scroll_sum);
          end
        end
      end

      S_FAIL: begin
        if (press) begin
          state_d     = S_IDLE;
          offset_d    = '0;
          speed_d     = 3'(INIT_SPEED);
          score_d     = '0;
          hit_d       = 1'b0;
          hit_cnt_d   = '0;
          fail_lane_d = '0;
          incoming_d  = '0;
          for (int r = 0; r < NUM_ROWS; r++) rows_d[r] = preload_lane(r);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign score     = score_q;
  assign speed     = speed_q;
  assign game_over = (state_q == S_FAIL);

  // Pixel mapping: y is shifted by the scroll offset; negative y is the incoming row.
  logic signed [10:0] pix_y;
  logic [10:0]        y_rem;
  logic [9:0]         x_rem;
  logic [RIW-1:0]     pix_row;
  logic               pix_incoming, pix_in_rows, pix_in_lanes;
  logic               pix_target, pix_grid;
  lane_t              pix_col, pix_tile;
  logic [11:0]        rgb_d, rgb_q;

  always_comb begin
    pix_y        = $signed({1'b0, DrawY}) - $signed(11'(offset_q));
    pix_incoming = (pix_y < 11'sd0);
    pix_row      = '0;
    y_rem        = '0;
    if (pix_incoming) begin
      y_rem = 11'(pix_y + $signed(11'(ROW_H)));
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (pix_y >= $signed(11'(r * ROW_H))) begin
          pix_row = RIW'(r);
          y_rem   = 11'(pix_y - $signed(11'(r * ROW_H)));
        end
      end
    end
    pix_in_rows = pix_incoming || (pix_y < $signed(11'(NUM_ROWS * ROW_H)));

    pix_col = '0;
    x_rem   = DrawX;
    for (int c = 1; c < NUM_LANES; c++) begin
      if (DrawX >= 10'(c * LANE_W)) begin
        pix_col = lane_t'(c);
        x_rem   = DrawX - 10'(c * LANE_W);
      end
    end
    pix_in_lanes = ({1'b0, DrawX} < 11'(NUM_LANES * LANE_W));

    pix_tile   = pix_incoming ? incoming_q : rows_q[pix_row];
    pix_target = !pix_incoming && (pix_row == RIW'(TARGET));
    pix_grid   = (x_rem == 10'd0) || (x_rem == 10'(LANE_W - 1)) ||
                 (y_rem == 11'd0) || (y_rem == 11'(ROW_H - 1));

    if (!blank || !pix_in_lanes || !pix_in_rows)
      rgb_d = RGB_OFF;
    else if (pix_grid)
      rgb_d = RGB_GRID;
    else if (state_q == S_FAIL && pix_target && pix_col == fail_lane_q)
      rgb_d = RGB_FAIL;
    else if (pix_target && hit_q && pix_col == pix_tile)
      rgb_d = RGB_HIT;
    else if (pix_col == pix_tile)
      rgb_d = RGB_TILE;
    else
      rgb_d = RGB_EMPTY;
  end

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) rgb_q <= RGB_OFF;
    else          rgb_q <= rgb_d;
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_tile_lane_engine.sv
// Self-checking bench for tile_lane_engine: directed game scenarios plus a
// randomized run, all compared against a cycle-level behavioural game model.
module tb_tile_lane_engine;

  localparam int NL     = 5;
  localparam int NR     = 4;
  localparam int LANE_W = 128;
  localparam int ROW_H  = 120;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FAIL = 2;

  logic        pixel_clk;
  logic        Reset_n;
  logic        vs;
  logic        blank;
  logic [7:0]  keycode;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  red, green, blue;
  logic [15:0] score;
  logic [2:0]  speed;
  logic        game_over;
  logic [11:0] rgb_obs;

  assign rgb_obs = {red, green, blue};

  tile_lane_engine dut (
    .pixel_clk (pixel_clk),
    .Reset_n   (Reset_n),
    .vs        (vs),
    .blank     (blank),
    .keycode   (keycode),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .score     (score),
    .speed     (speed),
    .game_over (game_over)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural game model ----------------
  bit [39:0]   keycodes = 40'h0E0D2C0907;
  int          m_rows [NR];
  int          m_inc, m_off, m_spd, m_score, m_hit, m_hc, m_fl, m_state;
  bit [7:0]    m_lfsr;
  bit [7:0]    m_kprev;
  bit          m_vsprev;
  logic [11:0] m_rgb;

  function automatic logic [7:0] key_of(input int lane);
    return keycodes[8*lane +: 8];
  endfunction

  function automatic int lane_of(input logic [7:0] k);
    for (int i = 0; i < NL; i++) if (keycodes[8*i +: 8] == k) return i;
    return -1;
  endfunction

  function automatic void model_init();
    for (int r = 0; r < NR; r++) m_rows[r] = r % NL;
    m_inc = 0; m_off = 0; m_spd = 1; m_score = 0;
    m_hit = 0; m_hc = 0; m_fl = 0; m_state = M_IDLE;
  endfunction

  function automatic logic [11:0] model_pixel(input int x, input int y, input bit blank_v);
    int yy, row, rem, col, xm, lane;
    if (!blank_v) return 12'h000;
    col = x / LANE_W;
    xm  = x % LANE_W;
    if (col >= NL) return 12'h000;
    yy = y - m_off;
    if (yy < 0) begin
      row = -1; rem = yy + ROW_H; lane = m_inc;
    end else begin
      row = yy / ROW_H; rem = yy % ROW_H;
      if (row >= NR) return 12'h000;
      lane = m_rows[row];
    end
    if (xm == 0 || xm == LANE_W - 1 || rem == 0 || rem == ROW_H - 1) return 12'h888;
    if (m_state == M_FAIL && row == NR - 1 && col == m_fl) return 12'hF00;
    if (row == NR - 1 && m_hit != 0 && col == lane) return 12'h0F0;
    if (col == lane) return 12'h000;
    return 12'hFFF;
  endfunction

  task automatic model_step();
    bit press, tick;
    int lane, spd_before;
    m_rgb      = model_pixel(int'(DrawX), int'(DrawY), blank);
    press      = (keycode != 8'd0) && (m_kprev == 8'd0);
    tick       = vs && !m_vsprev;
    m_kprev    = keycode;
    m_vsprev   = vs;
    lane       = lane_of(keycode);
    spd_before = m_spd;
    case (m_state)
      M_IDLE: if (press) m_state = M_RUN;
      M_RUN: begin
        if (press && lane >= 0) begin
          if (lane == m_rows[NR-1] && m_hit == 0) begin
            m_hit = 1;
            if (m_score < 65535) m_score++;
            m_hc++;
            if (m_hc == 8) begin
              m_hc = 0;
              if (m_spd < 7) m_spd++;
            end
          end else begin
            m_state = M_FAIL;
            m_fl    = lane;
          end
        end
        if (m_state == M_RUN && tick) begin
          if (m_off + spd_before >= ROW_H) begin
            if (m_hit == 0) begin
              m_state = M_FAIL;
              m_fl    = m_rows[NR-1];
            end else begin
              for (int r = NR - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
              m_rows[0] = m_inc;
              m_inc     = int'(m_lfsr) % NL;
              m_off     = m_off + spd_before - ROW_H;
              m_hit     = 0;
            end
          end else begin
            m_off += spd_before;
          end
        end
      end
      default: if (press) model_init();
    endcase
    if (tick) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  always @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      model_init();
      m_lfsr   = 8'hA5;
      m_kprev  = 8'd0;
      m_vsprev = 1'b0;
      m_rgb    = 12'h000;
    end else begin
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge pixel_clk) vs = 1'b1;
      @(negedge pixel_clk) vs = 1'b0;
    end
  endtask

  task automatic press_key(input logic [7:0] k);
    @(negedge pixel_clk) keycode = k;
    @(negedge pixel_clk) keycode = 8'd0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input bit blank_v,
                       input logic [11:0] exp);
    @(negedge pixel_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = blank_v;
    @(negedge pixel_clk);
    check(tag, rgb_obs, exp);
    check({tag, "_model"}, rgb_obs, m_rgb);
  endtask

  function automatic int cx(input int lane);
    return lane * LANE_W + 64;
  endfunction

  function automatic int cy(input int row);
    return m_off + row * ROW_H + 60;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; vs = 1'b0; blank = 1'b0; keycode = 8'd0; DrawX = '0; DrawY = '0;
    repeat (4) @(negedge pixel_clk);
    check("rst_score", score, 0);
    check("rst_speed", speed, 1);
    check("rst_game_over", game_over, 0);
    check("rst_rgb", rgb_obs, 12'h000);
    Reset_n = 1'b1;

    // Idle: frames do not scroll, preloaded diagonal pattern is shown.
    frames(10);
    check("idle_game_over", game_over, 0);
    check("idle_score", score, 0);
    probe("idle_r3_l3_black", cx(3), cy(3), 1'b1, 12'h000);
    probe("idle_r3_l0_white", cx(0), cy(3), 1'b1, 12'hFFF);
    probe("idle_r0_l0_black", cx(0), cy(0), 1'b1, 12'h000);
    probe("idle_r1_l0_white", cx(0), cy(1), 1'b1, 12'hFFF);
    probe("idle_grid_x", 128, 60, 1'b1, 12'h888);
    probe("idle_blank", cx(3), cy(3), 1'b0, 12'h000);

    // Start and hit the lane-3 target.
    press_key(8'h07);
    check("start_score", score, 0);
    press_key(8'h0D);
    check("hit1_score", score, 1);
    probe("hit1_target_green", cx(3), cy(3), 1'b1, 12'h0F0);

    // Miss: one shift after the hit, then the unhit lane-2 row reaches the shift point.
    frames(120);
    check("miss_after_shift", game_over, 0);
    frames(119);
    check("miss_before_tick", game_over, 0);
    frames(1);
    check("miss_on_tick", game_over, 1);
    probe("miss_cell_red", cx(2), cy(3), 1'b1, 12'hF00);

    // Restart, climb to a lane-1 target, then press the lane-4 key.
    press_key(8'h07);
    check("reinit_game_over", game_over, 0);
    check("reinit_score", score, 0);
    press_key(8'h07);
    press_key(8'h0D);
    frames(120);
    press_key(8'h2C);
    check("wrong_pre_score", score, 2);
    frames(120);
    press_key(8'h0E);
    check("wrong_key_fail", game_over, 1);
    probe("wrong_lane4_red", cx(4), cy(3), 1'b1, 12'hF00);
    probe("wrong_lane1_black", cx(1), cy(3), 1'b1, 12'h000);

    // Speed-up on the 8th hit and offset wrap 119+2 -> 1.
    press_key(8'h07);
    press_key(8'h07);
    for (int k = 1; k <= 7; k++) begin
      press_key(key_of(m_rows[NR-1]));
      check($sformatf("run_hit%0d_score", k), score, k);
      frames(120);
    end
    check("speed_before_8th", speed, 1);
    frames(119);
    press_key(key_of(m_rows[NR-1]));
    check("speed_after_8th", speed, 2);
    check("score_after_8th", score, 8);
    frames(1);
    check("wrap_no_fail", game_over, 0);
    probe("wrap_edge_y1", cx(1), 1, 1'b1, 12'h888);
    probe("wrap_inside_y2", cx(1), 2, 1'b1, model_pixel(cx(1), 2, 1'b1));

    // Held key is judged once.
    @(negedge pixel_clk) Reset_n = 1'b0;
    repeat (2) @(negedge pixel_clk);
    Reset_n = 1'b1;
    check("rst2_speed", speed, 1);
    press_key(8'h07);
    press_key(8'h0D);
    frames(120);
    press_key(8'h2C);
    frames(120);
    @(negedge pixel_clk) keycode = 8'h09;
    repeat (200) @(negedge pixel_clk);
    keycode = 8'd0;
    check("hold_score", score, 3);
    check("hold_game_over", game_over, 0);
    probe("hold_white", cx(0), cy(3), 1'b1, 12'hFFF);

    // Asynchronous reset mid-cycle.
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_rgb", rgb_obs, 12'h000);
    check("async_score", score, 0);
    check("async_speed", speed, 1);
    @(negedge pixel_clk) Reset_n = 1'b1;

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge pixel_clk);
      check("rnd_score", score, m_score);
      check("rnd_speed", speed, m_spd);
      check("rnd_game_over", game_over, (m_state == M_FAIL) ? 1 : 0);
      check("rnd_rgb", rgb_obs, m_rgb);
      if ($urandom_range(0, 1) == 0) vs = ~vs;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3: keycode = 8'd0;
          4, 5:       keycode = key_of(m_rows[NR-1]);
          6:          keycode = key_of(int'($urandom_range(0, NL - 1)));
          default:    keycode = 8'h1C;
        endcase
      end
      blank = ($urandom_range(0, 7) != 0);
      DrawX = 10'($urandom_range(0, 700));
      DrawY = 10'($urandom_range(0, 600));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
